// File: rtl/compressed_line_packer_pkg.sv
// compressed_line_packer_pkg
//   Shared definitions for the compressed line packer:
//   - state_t     : packer control states (IDLE, PACK, DRAIN, EMIT)
//   - count_width : width of the fill counter / o_line_bits for a line width
//   - sum_width   : width that holds count + sum of all lane lengths in one
//                   beat without wrapping
//   Optional feature macro used by the top: PACKER_STATS_EN.
package compressed_line_packer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // Bits needed to hold a fill count from 0 up to and including out_width.
  function automatic int count_width(input int out_width);
    return $clog2(out_width + 1);
  endfunction

  // Bits needed for a full line plus one maximal beat, so the fit test
  // against out_width never sees a wrapped value.
  function automatic int sum_width(input int out_width, input int lanes,
                                   input int token_width);
    return $clog2(out_width + lanes * token_width + 1);
  endfunction

endpackage

// File: rtl/compressed_line_packer_token_merge.sv
// token_merge
//   Combinational lane merger. Places each lane's token (lane 0 first) at the
//   running fill pointer of an MSB-aligned line and returns the OR-mask of all
//   placed bits together with the clamped sum of lane lengths.
//   Ports:
//     tokens  : LANES right-justified tokens, lane 0 in the LSB slice
//     lengths : per-lane bit length (0 = unused, > TOKEN_WIDTH clamps)
//     count   : current fill pointer (bits already used in the line)
//     mask    : bits to OR into the line buffer
//     sum     : sum of clamped lane lengths for this beat
module token_merge
  import compressed_line_packer_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int TOKEN_WIDTH = 34,
  parameter int LEN_WIDTH   = 6,
  parameter int OUT_WIDTH   = 128,
  parameter int COUNT_W     = count_width(OUT_WIDTH),
  parameter int SUM_W       = sum_width(OUT_WIDTH, LANES, TOKEN_WIDTH)
) (
  input  logic [LANES*TOKEN_WIDTH-1:0] tokens,
  input  logic [LANES*LEN_WIDTH-1:0]   lengths,
  input  logic [COUNT_W-1:0]           count,
  output logic [OUT_WIDTH-1:0]         mask,
  output logic [SUM_W-1:0]             sum
);

  localparam int EXT_W = OUT_WIDTH + TOKEN_WIDTH;

  logic [SUM_W-1:0]       len;
  logic [SUM_W-1:0]       end_pos;
  logic [TOKEN_WIDTH-1:0] tok;
  logic [EXT_W-1:0]       ext;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave one unassigned and infer a latch.
    mask    = '0;
    sum     = '0;
    len     = '0;
    end_pos = '0;
    tok     = '0;
    ext     = '0;
    for (int l = 0; l < LANES; l++) begin
      if (32'(lengths[l*LEN_WIDTH +: LEN_WIDTH]) > 32'(TOKEN_WIDTH))
        len = SUM_W'(TOKEN_WIDTH);
      else
        len = SUM_W'(lengths[l*LEN_WIDTH +: LEN_WIDTH]);
      // Keep only the low len bits of the token.
      tok = tokens[l*TOKEN_WIDTH +: TOKEN_WIDTH] & ~({TOKEN_WIDTH{1'b1}} << len);
      // Park the token just above the line, then shift right by the end
      // position: its LSB lands at OUT_WIDTH-1-(count+prior)-(len-1). Any
      // bits falling below bit 0 only occur on a beat that overflows anyway.
      end_pos = SUM_W'(count) + sum + len;
      ext     = {tok, {OUT_WIDTH{1'b0}}} >> end_pos;
      mask    = mask | ext[OUT_WIDTH-1:0];
      sum     = sum + len;
    end
  end

endmodule

// File: rtl/compressed_line_packer.sv
// compressed_line_packer
//   Packs beats of up to LANES variable-length tokens into MSB-aligned lines
//   of OUT_WIDTH bits. A beat that would overflow the line discards the line
//   contents; the remaining beats up to i_last are swallowed and the line is
//   emitted as all-zero with o_line_overflow set.
//   Ports:
//     i_clk, i_reset              : clock, synchronous active-high reset
//     i_valid/o_ready             : beat handshake (o_ready low only in EMIT)
//     i_tokens, i_lengths, i_last : beat payload
//     o_line, o_line_bits         : packed line and its valid bit count
//     o_line_overflow             : line overflowed, o_line is zero
//     o_line_valid/i_line_ready   : line handshake
//   Optional (macro PACKER_STATS_EN):
//     o_stat_lines, o_stat_overflows : saturating 32-bit handshake counters
module compressed_line_packer
  import compressed_line_packer_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int TOKEN_WIDTH = 34,
  parameter int LEN_WIDTH   = 6,
  parameter int OUT_WIDTH   = 128
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [LANES*TOKEN_WIDTH-1:0] i_tokens,
  input  logic [LANES*LEN_WIDTH-1:0]   i_lengths,
  input  logic                         i_last,
  output logic [OUT_WIDTH-1:0]         o_line,
  output logic [$clog2(OUT_WIDTH+1)-1:0] o_line_bits,
  output logic                         o_line_overflow,
  output logic                         o_line_valid,
  input  logic                         i_line_ready
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0]                  o_stat_lines,
  output logic [31:0]                  o_stat_overflows
`endif
);

  localparam int COUNT_W = count_width(OUT_WIDTH);
  localparam int SUM_W   = sum_width(OUT_WIDTH, LANES, TOKEN_WIDTH);

  state_t                 state, state_n;
  logic [COUNT_W-1:0]     count, count_n;
  logic [OUT_WIDTH-1:0]   line_buf, buf_n;
  logic                   ovf, ovf_n;
  logic [OUT_WIDTH-1:0]   line_n;
  logic [COUNT_W-1:0]     bits_n;
  logic                   lovf_n, lvalid_n;

  logic [OUT_WIDTH-1:0]   merge_mask;
  logic [SUM_W-1:0]       merge_sum;
  logic [SUM_W-1:0]       new_count;
  logic                   fits, accept, handshake;

  token_merge #(
    .LANES       (LANES),
    .TOKEN_WIDTH (TOKEN_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .COUNT_W     (COUNT_W),
    .SUM_W       (SUM_W)
  ) u_merge (
    .tokens  (i_tokens),
    .lengths (i_lengths),
    .count   (count),
    .mask    (merge_mask),
    .sum     (merge_sum)
  );

  assign o_ready   = (state != EMIT);
  assign accept    = i_valid && o_ready;
  assign handshake = o_line_valid && i_line_ready;
  assign new_count = SUM_W'(count) + merge_sum;
  assign fits      = (new_count <= SUM_W'(OUT_WIDTH));

  always_comb begin
    state_n  = state;
    count_n  = count;
    buf_n    = line_buf;
    ovf_n    = ovf;
    line_n   = o_line;
    bits_n   = o_line_bits;
    lovf_n   = o_line_overflow;
    lvalid_n = o_line_valid;
    unique case (state)
      IDLE, PACK: begin
        if (accept) begin
          if (fits) begin
            buf_n   = line_buf | merge_mask;
            count_n = COUNT_W'(new_count);
            if (i_last) begin
              state_n  = EMIT;
              line_n   = line_buf | merge_mask;
              bits_n   = COUNT_W'(new_count);
              lovf_n   = 1'b0;
              lvalid_n = 1'b1;
            end else begin
              state_n = PACK;
            end
          end else begin
            // Overflowing beat: drop it and everything already packed.
            buf_n   = '0;
            count_n = '0;
            ovf_n   = 1'b1;
            if (i_last) begin
              state_n  = EMIT;
              line_n   = '0;
              bits_n   = '0;
              lovf_n   = 1'b1;
              lvalid_n = 1'b1;
            end else begin
              state_n = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (accept && i_last) begin
          state_n  = EMIT;
          line_n   = '0;
          bits_n   = '0;
          lovf_n   = ovf;
          lvalid_n = 1'b1;
        end
      end
      EMIT: begin
        if (handshake) begin
          state_n  = IDLE;
          count_n  = '0;
          buf_n    = '0;
          ovf_n    = 1'b0;
          line_n   = '0;
          bits_n   = '0;
          lovf_n   = 1'b0;
          lvalid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      state           <= IDLE;
      count           <= '0;
      line_buf        <= '0;
      ovf             <= 1'b0;
      o_line          <= '0;
      o_line_bits     <= '0;
      o_line_overflow <= 1'b0;
      o_line_valid    <= 1'b0;
    end else begin
      state           <= state_n;
      count           <= count_n;
      line_buf        <= buf_n;
      ovf             <= ovf_n;
      o_line          <= line_n;
      o_line_bits     <= bits_n;
      o_line_overflow <= lovf_n;
      o_line_valid    <= lvalid_n;
    end
  end

`ifdef PACKER_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stat_lines     <= '0;
      o_stat_overflows <= '0;
    end else if (handshake) begin
      if (o_stat_lines != '1)
        o_stat_lines <= o_stat_lines + 32'd1;
      if (o_line_overflow && (o_stat_overflows != '1))
        o_stat_overflows <= o_stat_overflows + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_compressed_line_packer.sv
// tb_compressed_line_packer
//   Self-checking bench for compressed_line_packer (LANES=2, TOKEN_WIDTH=34,
//   OUT_WIDTH=128). The reference model keeps the line as a queue of bits in
//   transmission order; the expected line is that queue laid out from the MSB.
//   Build with +define+PACKER_STATS_EN to also check the statistics outputs.
module tb_compressed_line_packer;

  localparam int LANES = 2;
  localparam int TW    = 34;
  localparam int LW    = 6;
  localparam int OW    = 128;
  localparam int BW    = $clog2(OW + 1);

  logic                  i_clk = 1'b0;
  logic                  i_reset;
  logic                  i_valid;
  logic                  o_ready;
  logic [LANES*TW-1:0]   i_tokens;
  logic [LANES*LW-1:0]   i_lengths;
  logic                  i_last;
  logic [OW-1:0]         o_line;
  logic [BW-1:0]         o_line_bits;
  logic                  o_line_overflow;
  logic                  o_line_valid;
  logic                  i_line_ready;
`ifdef PACKER_STATS_EN
  logic [31:0]           o_stat_lines;
  logic [31:0]           o_stat_overflows;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit            mq[$];
  bit            movf;
  logic [OW-1:0] exp_line;
  int            lines_done;
  int            ovf_lines_done;

  always #5 i_clk = ~i_clk;

  compressed_line_packer #(
    .LANES       (LANES),
    .TOKEN_WIDTH (TW),
    .LEN_WIDTH   (LW),
    .OUT_WIDTH   (OW)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_tokens        (i_tokens),
    .i_lengths       (i_lengths),
    .i_last          (i_last),
    .o_line          (o_line),
    .o_line_bits     (o_line_bits),
    .o_line_overflow (o_line_overflow),
    .o_line_valid    (o_line_valid),
    .i_line_ready    (i_line_ready)
`ifdef PACKER_STATS_EN
    ,
    .o_stat_lines     (o_stat_lines),
    .o_stat_overflows (o_stat_overflows)
`endif
  );

  task automatic check(input string tag, input logic [OW-1:0] got,
                       input logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [LANES*TW-1:0] rand_tokens();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic drive_garbage(input logic valid);
    i_valid   = valid;
    i_tokens  = rand_tokens();
    i_lengths = LANES*LW'($urandom);
    i_last    = 1'($urandom);
  endtask

  task automatic model_clear();
    mq.delete();
    movf = 1'b0;
  endtask

  // Append one accepted beat to the model line.
  task automatic model_beat(input logic [LANES*TW-1:0] t,
                            input logic [LANES*LW-1:0] l);
    bit tmp[$];
    int len;
    if (movf) return;
    for (int ln = 0; ln < LANES; ln++) begin
      len = int'(l[ln*LW +: LW]);
      if (len > TW) len = TW;
      for (int b = len - 1; b >= 0; b--) tmp.push_back(t[ln*TW + b]);
    end
    if (mq.size() + tmp.size() > OW) begin
      mq.delete();
      movf = 1'b1;
    end else begin
      foreach (tmp[i]) mq.push_back(tmp[i]);
    end
  endtask

  task automatic send_beat(input logic [TW-1:0] t0, input logic [LW-1:0] l0,
                           input logic [TW-1:0] t1, input logic [LW-1:0] l1,
                           input logic last);
    check("ready_before_beat", o_ready, 1'b1);
    i_valid   = 1'b1;
    i_tokens  = {t1, t0};
    i_lengths = {l1, l0};
    i_last    = last;
    model_beat({t1, t0}, {l1, l0});
    tick();
    drive_garbage(1'b0);
  endtask

  task automatic expect_line(input string tag);
    exp_line = '0;
    foreach (mq[i]) exp_line[OW-1-i] = mq[i];
    check({tag, "_valid"}, o_line_valid, 1'b1);
    check({tag, "_ovf"}, o_line_overflow, movf);
    check({tag, "_line"}, o_line, exp_line);
    if (!movf) check({tag, "_bits"}, o_line_bits, OW'(mq.size()));
  endtask

  // Hold the line for 'hold' cycles with junk beats offered, then consume it.
  task automatic release_line(input string tag, input int hold);
    for (int c = 0; c < hold; c++) begin
      drive_garbage(1'b1);
      check({tag, "_hold_ready"}, o_ready, 1'b0);
      check({tag, "_hold_valid"}, o_line_valid, 1'b1);
      check({tag, "_hold_line"}, o_line, exp_line);
      tick();
    end
    drive_garbage(1'b1);
    i_line_ready = 1'b1;
    tick();
    i_line_ready = 1'b0;
    drive_garbage(1'b0);
    lines_done++;
    if (movf) ovf_lines_done++;
    model_clear();
    check({tag, "_drop_valid"}, o_line_valid, 1'b0);
    check({tag, "_ready_after"}, o_ready, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    i_reset = 1'b1;
    drive_garbage(1'b1);
    repeat (cycles) tick();
    i_reset = 1'b0;
    drive_garbage(1'b0);
    model_clear();
    lines_done     = 0;
    ovf_lines_done = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_line"}, o_line, '0);
    check({tag, "_bits"}, o_line_bits, '0);
    check({tag, "_ovf"}, o_line_overflow, 1'b0);
    check({tag, "_valid"}, o_line_valid, 1'b0);
    check({tag, "_ready"}, o_ready, 1'b1);
  endtask

  initial begin
    logic [TW-1:0] ta, tb;
    int nb, maxlen;
    i_line_ready = 1'b0;
    drive_garbage(1'b0);
    model_clear();

    // Reset held two cycles.
    do_reset(2);
    check_idle_outputs("reset");

    // Single beat: 0b10 (2 bits) then 0b1 (1 bit).
    send_beat(34'h2, 6'd2, 34'h1, 6'd1, 1'b1);
    expect_line("three_bits");
    check("three_bits_const", o_line, {3'b101, 125'b0});
    check("three_bits_cnt", o_line_bits, 3);
    release_line("three_bits", 0);

    // Exact fill with 16-bit tokens.
    for (int b = 0; b < 4; b++)
      send_beat(34'hAAAA, 6'd16, 34'h5555, 6'd16, b == 3);
    expect_line("exact_fill");
    check("exact_fill_const", o_line, {4{32'hAAAA5555}});
    check("exact_fill_cnt", o_line_bits, OW);
    release_line("exact_fill", 0);

    // Overflow on beat 2 with full-width tokens; beats 3-4 are drained.
    for (int b = 0; b < 4; b++)
      send_beat(TW'(rand_tokens()), 6'd34, TW'(rand_tokens()), 6'd34, b == 3);
    expect_line("overflow");
    check("overflow_zero", o_line, '0);
    check("overflow_flag", o_line_overflow, 1'b1);
    release_line("overflow", 0);

    // Line held for 5 cycles; a beat follows right after the handshake.
    send_beat(34'h3_1234_5678, 6'd34, 34'h0_0000_00FF, 6'd8, 1'b1);
    expect_line("hold");
    release_line("hold", 5);
    // Lengths above TOKEN_WIDTH clamp; junk above len is ignored.
    send_beat(34'h3_FFFF_FFFF, 6'd63, 34'h3_FFFF_FFF5, 6'd3, 1'b1);
    expect_line("clamp");
    check("clamp_cnt", o_line_bits, 37);
    release_line("clamp", 1);

    // Zero-length last beat on an empty line, then on a partial line.
    send_beat(TW'(rand_tokens()), 6'd0, TW'(rand_tokens()), 6'd0, 1'b1);
    expect_line("empty");
    check("empty_cnt", o_line_bits, 0);
    release_line("empty", 0);
    send_beat(34'h1F, 6'd5, 34'h0, 6'd0, 1'b0);
    send_beat(TW'(rand_tokens()), 6'd0, TW'(rand_tokens()), 6'd0, 1'b1);
    expect_line("zero_last");
    release_line("zero_last", 0);

    // Reset after 2 of 4 beats: the next line holds only new beats.
    send_beat(34'h3_0000_0001, 6'd20, 34'h7, 6'd3, 1'b0);
    send_beat(34'h5, 6'd4, 34'h9, 6'd4, 1'b0);
    do_reset(1);
    check_idle_outputs("mid_reset");
    for (int b = 0; b < 4; b++)
      send_beat(TW'(rand_tokens()), 6'd7, TW'(rand_tokens()), 6'd9, b == 3);
    expect_line("post_reset");
    release_line("post_reset", 0);

    // Reset while a line waits in EMIT discards it.
    send_beat(34'hF, 6'd4, 34'hF, 6'd4, 1'b1);
    expect_line("emit_reset_pre");
    do_reset(1);
    check_idle_outputs("emit_reset");

    // Randomized lines.
    for (int n = 0; n < 60; n++) begin
      nb = $urandom_range(1, 6);
      case ($urandom_range(0, 3))
        0: maxlen = 8;
        1: maxlen = 20;
        2: maxlen = 40;
        default: maxlen = 63;
      endcase
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin
          drive_garbage(1'b0);
          tick();
        end
        ta = TW'(rand_tokens());
        tb = TW'(rand_tokens());
        send_beat(ta, LW'($urandom_range(0, maxlen)), tb,
                  LW'($urandom_range(0, maxlen)), b == nb - 1);
      end
      expect_line("rand");
      release_line("rand", $urandom_range(0, 3));
    end

`ifdef PACKER_STATS_EN
    check("stat_lines", o_stat_lines, lines_done);
    check("stat_overflows", o_stat_overflows, ovf_lines_done);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/compressed_line_packer.md
COMPRESSED_LINE_PACKER -- requirements
Module: compressed_line_packer

Interface
REQ-001 SHALL have parameter LANES, default 2: compressed tokens accepted per beat.
REQ-002 SHALL have parameter TOKEN_WIDTH, default 34: maximum bits per token.
REQ-003 SHALL have parameter LEN_WIDTH, default 6: width of each token-length field.
REQ-004 SHALL have parameter OUT_WIDTH, default 128: packed line width in bits.
REQ-005 SHALL have port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port i_valid, input, 1: beat valid.
REQ-008 SHALL have port o_ready, output, 1: beat accepted when i_valid && o_ready.
REQ-009 SHALL have port i_tokens, input, LANES*TOKEN_WIDTH: right-justified tokens, lane 0 in the LSB slice.
REQ-010 SHALL have port i_lengths, input, LANES*LEN_WIDTH: bit length per lane; 0 means the lane is unused.
REQ-011 SHALL have port i_last, input, 1: the beat closes the current line.
REQ-012 SHALL have port o_line, output, OUT_WIDTH: packed line, MSB-aligned.
REQ-013 SHALL have port o_line_bits, output, $clog2(OUT_WIDTH+1): valid bit count of o_line.
REQ-014 SHALL have port o_line_overflow, output, 1: the line exceeded OUT_WIDTH and o_line is all-zero.
REQ-015 SHALL have port o_line_valid, output, 1: line valid.
REQ-016 SHALL have port i_line_ready, input, 1: line consumed when o_line_valid && i_line_ready.

Function
REQ-017 SHALL implement states IDLE, PACK, DRAIN, EMIT; o_ready = 1 in IDLE, PACK and DRAIN, and 0 in EMIT.
REQ-018 SHALL place tokens in lane order (lane 0 first) at the current fill pointer: bits [OUT_WIDTH-1-count -: len]; only the low len bits of each token are used.
REQ-019 SHALL treat any length > TOKEN_WIDTH as TOKEN_WIDTH.
REQ-020 SHALL compute new_count = count + sum(len) at a width that cannot wrap; if new_count <= OUT_WIDTH, merge the beat and set count = new_count.
REQ-021 SHALL, if new_count > OUT_WIDTH, discard the beat, clear the line buffer, and latch the overflow flag; go to DRAIN, or to EMIT if i_last is set.
REQ-022 SHALL, in DRAIN, accept and discard beats until a beat with i_last, then go to EMIT.
REQ-023 SHALL, on an accepted i_last beat in IDLE or PACK, go to EMIT with o_line_valid asserted on the next cycle (1-cycle latency).
REQ-024 SHALL hold o_line, o_line_bits, o_line_overflow and o_line_valid stable in EMIT until i_line_ready.
REQ-025 SHALL, on line handshake, clear count, buffer and flag, drop o_line_valid and return to IDLE; no new beat is accepted in that same cycle.
REQ-026 SHALL go from IDLE to PACK on an accepted non-last beat.
REQ-027 SHALL treat an all-zero-length beat with i_last as valid: it emits the bits accumulated so far (possibly 0).
REQ-028 SHALL report o_line_bits = OUT_WIDTH on an exact fill with no overflow.

Reset
REQ-029 SHALL, on i_reset, force state IDLE, count 0, buffer 0, o_line 0, o_line_bits 0, o_line_overflow 0, o_line_valid 0 and o_ready 1 from the next cycle, even mid-line or in EMIT; partial lines are lost.

Configuration
REQ-030 SHALL, with macro PACKER_STATS_EN defined, add 32-bit outputs o_stat_lines and o_stat_overflows: each increments on a line handshake (overflow lines only for the latter), saturates at all-ones, and clears on reset.
REQ-031 SHALL, without PACKER_STATS_EN, omit those ports and all counter logic.

Structure
REQ-032 SHALL place the state enum and the count-width constant in package compressed_line_packer_pkg.
REQ-033 SHALL implement lane merging as combinational sub-module token_merge: it takes the tokens, lengths and count and returns the shifted OR-mask and sum(len).
REQ-034 SHALL register all outputs except o_ready, which is decoded from the state.

Verification (LANES=2, TOKEN_WIDTH=34, OUT_WIDTH=128)
REQ-035 SHALL cover: hold reset 2 cycles -> all outputs 0 and o_ready=1 on the first cycle after release.
REQ-036 SHALL cover: one beat {lane0=0b10 len 2, lane1=0b1 len 1, last} -> next cycle o_line[127:125]=3'b101, all other bits 0, o_line_bits=3, overflow=0.
REQ-037 SHALL cover: 4 beats of two 16-bit tokens (0xAAAA, 0x5555), last on beat 4 -> o_line = {0xAAAA5555} repeated 4 times, o_line_bits=128, overflow=0.
REQ-038 SHALL cover: 4 beats of two 34-bit tokens, last on beat 4 -> beat 2 reaches 136 > 128, beats 3-4 are accepted and discarded, o_line=0, o_line_overflow=1.
REQ-039 SHALL cover: i_line_ready held low 5 cycles during EMIT -> o_line stable and o_ready=0 throughout; release -> o_line_valid drops the next cycle and a new beat is accepted one cycle later.
REQ-040 SHALL cover: i_reset asserted after 2 of 4 beats -> the next line contains only post-reset beats; with PACKER_STATS_EN, o_stat_lines counts only completed handshakes.
